// File: rtl/ucsbece154b_hazard_unit_pkg.sv
// Shared encodings and types for the pipeline hazard/forwarding unit.
// Contents: forwarding-mux encodings, ResultSrc load encoding, and a
// packed bundle of the per-stage stall/flush enables.
package ucsbece154b_hazard_unit_pkg;

  // Forwarding mux select for the E-stage ALU operands
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value from D/E reg
  localparam logic [1:0] FWD_W  = 2'b01;  // result being written back in W
  localparam logic [1:0] FWD_M  = 2'b10;  // ALU result sitting in M

  // ResultSrc value marking a load instruction
  localparam logic [1:0] RESSRC_LOAD = 2'b01;

  // Stall/flush enables for all pipeline registers, MSB first as listed
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_IDLE = '0;

  // A destination can be forwarded to a source when it is written, non-x0,
  // and names the same register.
  function automatic logic fwd_hit(input logic [7:0] rs, input logic [7:0] rd,
                                   input logic       we);
    return we && (rs != 8'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/ucsbece154b_fwd_sel.sv
// Forwarding select for one E-stage operand.
// Ports: i_rs (source reg in E), i_rd_m/i_we_m (M destination + write enable),
//        i_rd_w/i_we_w (W destination + write enable), o_sel (FWD_* encoding).
// Purely combinational; M has priority over W since it holds the younger value.
module ucsbece154b_fwd_sel
  import ucsbece154b_hazard_unit_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] i_rs,
  input  logic [REGW-1:0] i_rd_m,
  input  logic            i_we_m,
  input  logic [REGW-1:0] i_rd_w,
  input  logic            i_we_w,
  output logic [1:0]      o_sel
);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = fwd_hit(8'(i_rs), 8'(i_rd_m), i_we_m);
  assign w_hit_w = fwd_hit(8'(i_rs), 8'(i_rd_w), i_we_w);

  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_m) begin
      o_sel = FWD_M;
    end else if (w_hit_w) begin
      o_sel = FWD_W;
    end
  end

endmodule

// File: rtl/ucsbece154b_hazard_unit.sv
// Hazard and forwarding unit for the 5-stage RV32 pipeline.
// Inputs: register indices / write enables of D, E, M, W; load flag, branch
//   resolution, mul/div occupancy in E, data-memory request/ready in M.
// Outputs: stall enables for F/D/E/M regs, flush enables for D/E/M/W regs,
//   operand forwarding selects, mul/div busy flag and a saturating count of
//   fetch-stall cycles. Stall priority: memory > mul/div > load-use/branch.
module ucsbece154b_hazard_unit
  import ucsbece154b_hazard_unit_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int MDLAT = 4,
  parameter int CNTW  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREG)-1:0]  Rs1D_i,
  input  logic [$clog2(NREG)-1:0]  Rs2D_i,
  input  logic [$clog2(NREG)-1:0]  Rs1E_i,
  input  logic [$clog2(NREG)-1:0]  Rs2E_i,
  input  logic [$clog2(NREG)-1:0]  RdE_i,
  input  logic [$clog2(NREG)-1:0]  RdM_i,
  input  logic [$clog2(NREG)-1:0]  RdW_i,
  input  logic                     RegWriteE_i,
  input  logic                     RegWriteM_i,
  input  logic                     RegWriteW_i,
  input  logic [1:0]               ResultSrcE_i,
  input  logic                     PCSrcE_i,
  input  logic                     MdE_i,
  input  logic                     MemReqM_i,
  input  logic                     MemReadyM_i,
  output logic                     StallF_o,
  output logic                     StallD_o,
  output logic                     StallE_o,
  output logic                     StallM_o,
  output logic                     FlushD_o,
  output logic                     FlushE_o,
  output logic                     FlushM_o,
  output logic                     FlushW_o,
  output logic [1:0]               ForwardAE_o,
  output logic [1:0]               ForwardBE_o,
  output logic                     MdBusy_o,
  output logic [CNTW-1:0]          StallCnt_o
);

  localparam int REGW = $clog2(NREG);
  // Counter needs at least one bit even when MDLAT=1 (it then never leaves 0)
  localparam int MDW  = (MDLAT > 1) ? $clog2(MDLAT) : 1;

  localparam logic [MDW-1:0]  MD_LAST = MDW'(MDLAT - 1);
  localparam logic [MDW-1:0]  MD_ONE  = MDW'(1);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [MDW-1:0]  r_mdcnt;
  logic [CNTW-1:0] r_stall_cnt;

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  logic            w_mem_stall;
  logic            w_md_done;
  logic            w_md_stall;
  logic            w_lw_match;
  logic            w_lw_stall;
  logic            w_taken;
  hz_ctrl_t        w_ctrl;
  logic [MDW-1:0]  w_mdcnt_nxt;
  logic [1:0]      w_fwd_a;
  logic [1:0]      w_fwd_b;

  // Memory not acknowledging freezes everything up to M; W gets a bubble
  // because the M instruction has not produced its result yet.
  assign w_mem_stall = MemReqM_i & ~MemReadyM_i;

  // The op in E finishes on its last occupancy cycle. A memory stall masks
  // the mul/div stall: the pipe is already frozen and FlushM must not fire.
  assign w_md_done  = (r_mdcnt == MD_LAST);
  assign w_md_stall = MdE_i & ~w_md_done & ~w_mem_stall;

  assign w_lw_match = (RdE_i != '0) &&
                      ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
  assign w_lw_stall = (ResultSrcE_i == RESSRC_LOAD) & RegWriteE_i & w_lw_match &
                      ~w_mem_stall & ~w_md_stall;

  // A redirect in E only acts when E is actually advancing; while E is held
  // the branch is still there and resolves on the release cycle.
  assign w_taken = PCSrcE_i & ~(w_mem_stall | w_md_stall);

  always_comb begin
    w_ctrl = HZ_IDLE;
    if (!reset) begin
      w_ctrl.stall_f = w_mem_stall | w_md_stall | w_lw_stall;
      w_ctrl.stall_d = w_mem_stall | w_md_stall | w_lw_stall;
      w_ctrl.stall_e = w_mem_stall | w_md_stall;
      w_ctrl.stall_m = w_mem_stall;
      // Load-use bubble and the branch squash both clear E; they can coexist.
      w_ctrl.flush_d = w_taken;
      w_ctrl.flush_e = w_taken | w_lw_stall;
      w_ctrl.flush_m = w_md_stall;
      w_ctrl.flush_w = w_mem_stall;
    end
  end

  assign StallF_o = w_ctrl.stall_f;
  assign StallD_o = w_ctrl.stall_d;
  assign StallE_o = w_ctrl.stall_e;
  assign StallM_o = w_ctrl.stall_m;
  assign FlushD_o = w_ctrl.flush_d;
  assign FlushE_o = w_ctrl.flush_e;
  assign FlushM_o = w_ctrl.flush_m;
  assign FlushW_o = w_ctrl.flush_w;

  // ---------------------------------------------------------------------
  // Mul/div occupancy counter
  // ---------------------------------------------------------------------
  // The unit keeps computing while the pipe is frozen by memory, so the count
  // advances under memStall too and parks at MD_LAST until E may release.
  always_comb begin
    w_mdcnt_nxt = r_mdcnt;
    if (!MdE_i) begin
      w_mdcnt_nxt = '0;
    end else if (!w_md_done) begin
      w_mdcnt_nxt = r_mdcnt + MD_ONE;
    end else if (!w_mem_stall) begin
      w_mdcnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mdcnt <= '0;
    end else begin
      r_mdcnt <= w_mdcnt_nxt;
    end
  end

  assign MdBusy_o = (r_mdcnt != '0);

  // ---------------------------------------------------------------------
  // Fetch-stall cycle counter (saturating)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_ctrl.stall_f && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign StallCnt_o = r_stall_cnt;

  // ---------------------------------------------------------------------
  // Operand forwarding
  // ---------------------------------------------------------------------
  ucsbece154b_fwd_sel #(.REGW(REGW)) u_fwd_a (
    .i_rs   (Rs1E_i),
    .i_rd_m (RdM_i),
    .i_we_m (RegWriteM_i),
    .i_rd_w (RdW_i),
    .i_we_w (RegWriteW_i),
    .o_sel  (w_fwd_a)
  );

  ucsbece154b_fwd_sel #(.REGW(REGW)) u_fwd_b (
    .i_rs   (Rs2E_i),
    .i_rd_m (RdM_i),
    .i_we_m (RegWriteM_i),
    .i_rd_w (RdW_i),
    .i_we_w (RegWriteW_i),
    .o_sel  (w_fwd_b)
  );

  assign ForwardAE_o = reset ? FWD_RF : w_fwd_a;
  assign ForwardBE_o = reset ? FWD_RF : w_fwd_b;

endmodule

// File: tb/tb_ucsbece154b_hazard_unit.sv
module tb_ucsbece154b_hazard_unit;

  logic clk;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic PCSrcE, MdE, MemReqM, MemReadyM;

  // main instance: MDLAT=4, CNTW=16
  logic sF, sD, sE, sM, fD, fE, fM, fW, busy;
  logic [1:0] fa, fb;
  logic [15:0] cnt;
  // CNTW=4 instance
  logic c_sF, c_sD, c_sE, c_sM, c_fD, c_fE, c_fM, c_fW, c_busy;
  logic [1:0] c_fa, c_fb;
  logic [3:0] c_cnt;
  // MDLAT=1 instance
  logic m_sF, m_sD, m_sE, m_sM, m_fD, m_fE, m_fM, m_fW, m_busy;
  logic [1:0] m_fa, m_fb;
  logic [15:0] m_cnt;

  logic [7:0] ctrl, m_ctrl;
  assign ctrl   = {sF, sD, sE, sM, fD, fE, fM, fW};
  assign m_ctrl = {m_sF, m_sD, m_sE, m_sM, m_fD, m_fE, m_fM, m_fW};

  ucsbece154b_hazard_unit #(.NREG(32), .MDLAT(4), .CNTW(16)) dut (
    .clk(clk), .reset(reset),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
    .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW),
    .RegWriteE_i(RegWriteE), .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
    .ResultSrcE_i(ResultSrcE), .PCSrcE_i(PCSrcE), .MdE_i(MdE),
    .MemReqM_i(MemReqM), .MemReadyM_i(MemReadyM),
    .StallF_o(sF), .StallD_o(sD), .StallE_o(sE), .StallM_o(sM),
    .FlushD_o(fD), .FlushE_o(fE), .FlushM_o(fM), .FlushW_o(fW),
    .ForwardAE_o(fa), .ForwardBE_o(fb), .MdBusy_o(busy), .StallCnt_o(cnt)
  );

  ucsbece154b_hazard_unit #(.NREG(32), .MDLAT(4), .CNTW(4)) dut_c4 (
    .clk(clk), .reset(reset),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
    .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW),
    .RegWriteE_i(RegWriteE), .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
    .ResultSrcE_i(ResultSrcE), .PCSrcE_i(PCSrcE), .MdE_i(MdE),
    .MemReqM_i(MemReqM), .MemReadyM_i(MemReadyM),
    .StallF_o(c_sF), .StallD_o(c_sD), .StallE_o(c_sE), .StallM_o(c_sM),
    .FlushD_o(c_fD), .FlushE_o(c_fE), .FlushM_o(c_fM), .FlushW_o(c_fW),
    .ForwardAE_o(c_fa), .ForwardBE_o(c_fb), .MdBusy_o(c_busy), .StallCnt_o(c_cnt)
  );

  ucsbece154b_hazard_unit #(.NREG(32), .MDLAT(1), .CNTW(16)) dut_m1 (
    .clk(clk), .reset(reset),
    .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E),
    .RdE_i(RdE), .RdM_i(RdM), .RdW_i(RdW),
    .RegWriteE_i(RegWriteE), .RegWriteM_i(RegWriteM), .RegWriteW_i(RegWriteW),
    .ResultSrcE_i(ResultSrcE), .PCSrcE_i(PCSrcE), .MdE_i(MdE),
    .MemReqM_i(MemReqM), .MemReadyM_i(MemReadyM),
    .StallF_o(m_sF), .StallD_o(m_sD), .StallE_o(m_sE), .StallM_o(m_sM),
    .FlushD_o(m_fD), .FlushE_o(m_fE), .FlushM_o(m_fM), .FlushW_o(m_fW),
    .ForwardAE_o(m_fa), .ForwardBE_o(m_fb), .MdBusy_o(m_busy), .StallCnt_o(m_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // expected ctrl bit order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
  typedef struct {
    string      name;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwe, rwm, rww;
    logic [1:0] ressrc;
    logic       pcsrc, memreq, memrdy;
    logic [7:0] exp_ctrl;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  function automatic vec_t mkv(input string nm,
                               input logic [4:0] rs1d, input logic [4:0] rs2d,
                               input logic [4:0] rs1e, input logic [4:0] rs2e,
                               input logic [4:0] rde, input logic [4:0] rdm,
                               input logic [4:0] rdw,
                               input logic rwe, input logic rwm, input logic rww,
                               input logic [1:0] ressrc, input logic pcsrc,
                               input logic memreq, input logic memrdy,
                               input logic [7:0] ec, input logic [1:0] ea,
                               input logic [1:0] eb);
    vec_t v;
    v.name = nm;
    v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw;
    v.rwe = rwe; v.rwm = rwm; v.rww = rww;
    v.ressrc = ressrc; v.pcsrc = pcsrc; v.memreq = memreq; v.memrdy = memrdy;
    v.exp_ctrl = ec; v.exp_fa = ea; v.exp_fb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
    PCSrcE = 0; MdE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic apply(input vec_t v);
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
    RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww;
    ResultSrcE = v.ressrc; PCSrcE = v.pcsrc; MdE = 1'b0;
    MemReqM = v.memreq; MemReadyM = v.memrdy;
  endtask

  // leaves the bench 1 time unit after a rising edge with reset released
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;

    //                 name        rs1d rs2d rs1e rs2e rde rdm rdw rwe rwm rww res   pc mq mr  ctrl         fa     fb
    tbl[0]  = mkv("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 8'b0000_0000, 2'b00, 2'b00);
    tbl[1]  = mkv("lw_rs1",     5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 8'b1100_0100, 2'b00, 2'b00);
    tbl[2]  = mkv("lw_rd0",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 8'b0000_0000, 2'b00, 2'b00);
    tbl[3]  = mkv("lw_rs2",     6, 5, 0, 0, 5, 0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 8'b1100_0100, 2'b00, 2'b00);
    tbl[4]  = mkv("lw_nowr",    5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 8'b0000_0000, 2'b00, 2'b00);
    tbl[5]  = mkv("alu_e",      5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 8'b0000_0000, 2'b00, 2'b00);
    tbl[6]  = mkv("branch",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 8'b0000_1100, 2'b00, 2'b00);
    tbl[7]  = mkv("lw_branch",  5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 2'b01, 1, 0, 0, 8'b1100_1100, 2'b00, 2'b00);
    tbl[8]  = mkv("memstall",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 8'b1111_0001, 2'b00, 2'b00);
    tbl[9]  = mkv("mem_lw_br",  5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 2'b01, 1, 1, 0, 8'b1111_0001, 2'b00, 2'b00);
    tbl[10] = mkv("mem_ack",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1, 8'b0000_0000, 2'b00, 2'b00);
    tbl[11] = mkv("fwd_m",      0, 0, 7, 0, 0, 7, 7, 0, 1, 1, 2'b00, 0, 0, 0, 8'b0000_0000, 2'b10, 2'b00);
    tbl[12] = mkv("fwd_w",      0, 0, 7, 0, 0, 7, 7, 0, 0, 1, 2'b00, 0, 0, 0, 8'b0000_0000, 2'b01, 2'b00);
    tbl[13] = mkv("fwd_x0",     0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 8'b0000_0000, 2'b00, 2'b00);
    tbl[14] = mkv("fwd_ab",     0, 0, 4, 3, 0, 4, 3, 0, 1, 1, 2'b00, 0, 0, 0, 8'b0000_0000, 2'b10, 2'b01);
    tbl[15] = mkv("fwd_stall",  0, 0, 9, 0, 0, 9, 0, 0, 1, 0, 2'b00, 0, 1, 0, 8'b1111_0001, 2'b10, 2'b00);
    tbl[16] = mkv("fwd_nowr",   0, 0, 7, 7, 0, 7, 7, 0, 0, 0, 2'b00, 0, 0, 0, 8'b0000_0000, 2'b00, 2'b00);

    // ---- reset state: hazard-triggering inputs must be masked ----
    clear_inputs();
    reset = 1'b1;
    apply(tbl[9]);
    Rs1E = 7; RdM = 7; RegWriteM = 1;
    @(negedge clk);
    chk("reset ctrl", 32'(ctrl), 32'h0);
    chk("reset fwdA", 32'(fa), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset cnt", 32'(cnt), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_inputs();

    // ---- combinational table ----
    for (int i = 0; i < NV; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("tbl[%0d] %s ctrl", i, tbl[i].name), 32'(ctrl), 32'(tbl[i].exp_ctrl));
      chk($sformatf("tbl[%0d] %s fwdA", i, tbl[i].name), 32'(fa), 32'(tbl[i].exp_fa));
      chk($sformatf("tbl[%0d] %s fwdB", i, tbl[i].name), 32'(fb), 32'(tbl[i].exp_fb));
      next_cycle();
    end

    // ---- mul/div occupancy, MDLAT=4 ----
    do_reset();
    MdE = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("md cyc%0d ctrl", k), 32'(ctrl), (k < 4) ? 32'hE2 : 32'h00);
      chk($sformatf("md cyc%0d busy", k), 32'(busy), (k >= 2) ? 32'h1 : 32'h0);
      chk($sformatf("md1 cyc%0d ctrl", k), 32'(m_ctrl), 32'h00);
      chk($sformatf("md1 cyc%0d busy", k), 32'(m_busy), 32'h0);
      next_cycle();
    end
    // counter wrapped to 0; a back-to-back mul/div starts a fresh occupancy
    @(negedge clk);
    chk("md after busy", 32'(busy), 32'h0);
    chk("md after ctrl", 32'(ctrl), 32'hE2);
    next_cycle();
    MdE = 1'b0;

    // ---- memory stall during mul/div: counter saturates ----
    do_reset();
    MdE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("mdmem cyc%0d ctrl", k), 32'(ctrl), 32'hF1);
      chk($sformatf("mdmem cyc%0d busy", k), 32'(busy), (k >= 2) ? 32'h1 : 32'h0);
      next_cycle();
    end
    MemReadyM = 1'b1;
    @(negedge clk);
    chk("mdmem ack ctrl", 32'(ctrl), 32'h00);
    chk("mdmem ack busy", 32'(busy), 32'h1);
    next_cycle();
    MdE = 1'b0; MemReqM = 1'b0;
    @(negedge clk);
    chk("mdmem done busy", 32'(busy), 32'h0);
    next_cycle();

    // ---- branch held behind a memory stall ----
    do_reset();
    PCSrcE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk($sformatf("brmem cyc%0d ctrl", k), 32'(ctrl), 32'hF1);
      next_cycle();
    end
    MemReadyM = 1'b1;
    @(negedge clk);
    chk("brmem ack ctrl", 32'(ctrl), 32'h0C);
    next_cycle();
    PCSrcE = 1'b0; MemReqM = 1'b0;
    @(negedge clk);
    chk("brmem after ctrl", 32'(ctrl), 32'h00);
    next_cycle();

    // ---- stall counter saturation ----
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    repeat (20) next_cycle();
    @(negedge clk);
    chk("cnt4 saturate", 32'(c_cnt), 32'hF);
    chk("cnt16 count", 32'(cnt), 32'd20);
    next_cycle();
    MemReqM = 1'b0;

    // ---- reset in the middle of a mul/div ----
    do_reset();
    MdE = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("mdrst pre busy", 32'(busy), 32'h1);
    #1;
    reset = 1'b1;
    MemReqM = 1'b1; MemReadyM = 1'b0;
    #1;
    chk("mdrst busy", 32'(busy), 32'h0);
    chk("mdrst ctrl", 32'(ctrl), 32'h00);
    chk("mdrst cnt", 32'(cnt), 32'h0);
    chk("mdrst cnt4", 32'(c_cnt), 32'h0);
    next_cycle();
    reset = 1'b0;
    MemReqM = 1'b0;
    @(negedge clk);
    chk("mdrst restart ctrl", 32'(ctrl), 32'hE2);
    chk("mdrst restart busy", 32'(busy), 32'h0);
    next_cycle();
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
